// File: rtl/regm.sv
// Integer register file: 31 x 32-bit storage (x0 hardwired to zero), one write
// port from write-back, two combinational decode read ports and a debug port.
module regm #(
  parameter bit          BYPASS_EN   = 1'b1,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        write_i,
  input  logic [4:0]  write_addr_i,
  input  logic [31:0] write_data_i,
  input  logic [4:0]  rdata1_addr_i,
  output logic [31:0] rdata1_o,
  input  logic [4:0]  rdata2_addr_i,
  output logic [31:0] rdata2_o,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic            wen;
  logic [XLEN-1:0] stored1;
  logic [XLEN-1:0] stored2;
  logic [XLEN-1:0] stored_dbg;
  logic            byp1;
  logic            byp2;

  assign wen = write_i && (write_addr_i != '0);

  // Storage for x1..x31; x0 has no flop and writes to it fall through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 1; k < NREG; k++) begin
        regs_q[k] <= RESET_VALUE;
      end
    end else begin
      for (int unsigned k = 1; k < NREG; k++) begin
        if (wen && (write_addr_i == AW'(k))) begin
          regs_q[k] <= write_data_i;
        end
      end
    end
  end

  // Read muxes over stored contents; index 0 selects nothing and yields zero.
  always_comb begin
    stored1    = '0;
    stored2    = '0;
    stored_dbg = '0;
    for (int unsigned k = 1; k < NREG; k++) begin
      if (rdata1_addr_i == AW'(k)) stored1    = regs_q[k];
      if (rdata2_addr_i == AW'(k)) stored2    = regs_q[k];
      if (dbg_addr_i    == AW'(k)) stored_dbg = regs_q[k];
    end
  end

  // Bypass only for a live, non-x0 write outside reset.
  assign byp1 = BYPASS_EN && rst_ni && wen && (write_addr_i == rdata1_addr_i);
  assign byp2 = BYPASS_EN && rst_ni && wen && (write_addr_i == rdata2_addr_i);

  assign rdata1_o   = byp1 ? write_data_i : stored1;
  assign rdata2_o   = byp2 ? write_data_i : stored2;
  assign dbg_data_o = stored_dbg;

endmodule

// File: doc/regm.md
Name: regm

Overview:
- Integer register file: the receiving end of the write-back stage's register write interface (write enable, 5-bit address, 32-bit data).
- Serves two combinational read ports to the decode stage.
- 32 x 32-bit registers; x0 is hardwired to zero.
- Optional write-to-read bypass, so a value being written is visible to decode in the same cycle.

Parameters:
- BYPASS_EN, 1, 1: read ports return in-flight write data on an address match; 0: read ports return stored contents only.
- RESET_VALUE, 32'h00000000, value loaded into registers x1..x31 on reset.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_ni  input  1  asynchronous active-low reset
- write_i  input  1  write enable from write-back
- write_addr_i  input  5  destination register index
- write_data_i  input  32  data to write
- rdata1_addr_i  input  5  read port 1 index
- rdata1_o  output  32  read port 1 data
- rdata2_addr_i  input  5  read port 2 index
- rdata2_o  output  32  read port 2 data
- dbg_addr_i  input  5  debug/observation read index (never bypassed)
- dbg_data_o  output  32  stored contents of register dbg_addr_i

Behaviour:
- Storage: 31 flops of 32 bits (x1..x31). x0 has no storage.
- Reset:
  - rst_ni low clears x1..x31 to RESET_VALUE immediately, with no clock needed.
  - While rst_ni is low, rdataN_o and dbg_data_o reflect the reset contents (RESET_VALUE, or 0 for index 0).
  - Writes are ignored while rst_ni is low.
  - Release of reset is synchronised externally; the first write takes effect on the first rising edge with rst_ni high.
- Write:
  - On a rising edge with rst_ni=1 and write_i=1 and write_addr_i != 0, register[write_addr_i] <= write_data_i.
  - write_addr_i == 0: the write is discarded silently.
  - write_i=0: no state change; write_addr_i and write_data_i are don't-care.
- Read, combinational (zero-cycle latency):
  - rdataN_o = 0 if rdataN_addr_i == 0.
  - Otherwise, if BYPASS_EN=1 and write_i=1 and write_addr_i == rdataN_addr_i, rdataN_o = write_data_i (bypass).
  - Otherwise, rdataN_o = register[rdataN_addr_i].
  - The bypass is never applied for index 0, even when write_i=1 with write_addr_i=0.
  - The bypass is gated by rst_ni: while in reset, no bypass.
- Both read ports may select the same index, and either or both may match the write index; each port resolves independently.
- Debug port: dbg_data_o = 0 for index 0, otherwise register[dbg_addr_i]. Never bypassed; it shows the committed state only.
- No stall or handshake. A write is accepted every cycle it is presented.
- Back-to-back writes to the same index: the last one wins. Each is visible through the bypass in its own cycle and through storage from the next cycle.
- Reset mid-operation: a write presented in the same cycle rst_ni falls is lost, and the register holds RESET_VALUE.
- No X propagation: every output is defined for every input combination once reset has been applied.

Test Plan:
1. Reset with RESET_VALUE=0: assert rst_ni=0 with no clock edge -> rdata1_o, rdata2_o and dbg_data_o all read 0 for indices 0, 5 and 31.
2. Write then read:
   - write_i=1, addr=7, data=32'hDEADBEEF for one edge, then write_i=0.
   - -> next cycle, rdata1_addr_i=7 gives 32'hDEADBEEF and dbg_addr_i=7 gives 32'hDEADBEEF.
3. x0 protection: write_i=1, addr=0, data=32'hFFFFFFFF -> same cycle and following cycles, rdata1_o=0 and dbg_data_o=0 for index 0.
4. Bypass with BYPASS_EN=1:
   - Register 3 holds 32'h11111111. Present write_i=1, addr=3, data=32'h22222222 with rdata1_addr_i=3 and rdata2_addr_i=3.
   - -> same cycle: rdata1_o = rdata2_o = 32'h22222222 and dbg_data_o = 32'h11111111.
   - -> after the edge: all three read 32'h22222222.
   - Repeat with BYPASS_EN=0 -> both read ports show 32'h11111111 until the edge.
5. Async reset mid-stream:
   - Registers 1..31 written with value i.
   - Drop rst_ni between edges -> all read RESET_VALUE immediately.
   - A write presented on the edge while rst_ni=0 is not stored.
6. Sweep: write i*32'h01010101 to every index 1..31 on consecutive edges, then read all pairs (i, 32-i) -> each port returns its expected value; index 0 returns 0.
